// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V execution definitions.
//   - ALUOP_WIDTH and the *_OP ALU op code encodings produced by ALU control.
//   - alu_shift_state_t: state of the optional serial shift engine
//     (used only when SERIAL_SHIFT_EN is defined).
//   - is_shift_op(): true for SLL/SRL/SRA.
package riscv_pkg;

  localparam int ALUOP_WIDTH = 4;

  localparam logic [ALUOP_WIDTH-1:0] ADD_OP  = 4'd0;
  localparam logic [ALUOP_WIDTH-1:0] SUB_OP  = 4'd1;
  localparam logic [ALUOP_WIDTH-1:0] SLL_OP  = 4'd2;
  localparam logic [ALUOP_WIDTH-1:0] SLT_OP  = 4'd3;
  localparam logic [ALUOP_WIDTH-1:0] SLTU_OP = 4'd4;
  localparam logic [ALUOP_WIDTH-1:0] XOR_OP  = 4'd5;
  localparam logic [ALUOP_WIDTH-1:0] SRL_OP  = 4'd6;
  localparam logic [ALUOP_WIDTH-1:0] SRA_OP  = 4'd7;
  localparam logic [ALUOP_WIDTH-1:0] OR_OP   = 4'd8;
  localparam logic [ALUOP_WIDTH-1:0] AND_OP  = 4'd9;
  localparam logic [ALUOP_WIDTH-1:0] PASS_OP = 4'd10;
  // Codes 11..15 are unassigned; the ALU returns 0 for them.

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } alu_shift_state_t;

  function automatic logic is_shift_op(input logic [ALUOP_WIDTH-1:0] op);
    return (op == SLL_OP) || (op == SRL_OP) || (op == SRA_OP);
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: shift datapath for alu_exec_unit.
//   Macro SERIAL_SHIFT_EN:
//     undefined -> single-cycle barrel shifter, o_done is always 1.
//     defined   -> serial engine, 1 bit per cycle, IDLE/SHIFT FSM.
// Ports:
//   clk, reset   (serial build only) clock, synchronous active-high reset
//   i_valid      (serial build only) a shift beat is sitting in S1
//   i_advance    (serial build only) S1 hands its beat to S2 this cycle
//   i_op         ALU op code (SLL/SRL/SRA select the shift kind)
//   i_data       value to shift
//   i_shamt      shift amount
//   o_result     shifted value
//   o_done       o_result is final for the beat in S1
module alu_shifter
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
`ifdef SERIAL_SHIFT_EN
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_valid,
  input  logic                          i_advance,
`endif
  input  logic [ALUOP_WIDTH-1:0]        i_op,
  input  logic [DATA_WIDTH-1:0]         i_data,
  input  logic [$clog2(DATA_WIDTH)-1:0] i_shamt,
  output logic [DATA_WIDTH-1:0]         o_result,
  output logic                          o_done
);

`ifdef SERIAL_SHIFT_EN

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  alu_shift_state_t    r_state;
  alu_shift_state_t    w_state_next;
  logic [DATA_WIDTH-1:0] r_work;
  logic [DATA_WIDTH-1:0] w_step;
  logic [SHAMT_W-1:0]  r_count;
  logic                r_done;   // shift finished but S2 had no room yet
  logic                w_start;
  logic                w_last;

  // A beat starts shifting once, on its first cycle in S1; r_done stops a
  // finished-but-stalled beat from restarting.
  assign w_start = i_valid && (r_state == IDLE) && !r_done && (i_shamt != '0);
  // The final bit is applied combinationally so the result can leave S1 in
  // the same cycle the counter expires: total latency 2 + shamt.
  assign w_last  = (r_state == SHIFT) && (r_count == SHAMT_W'(1));

  always_comb begin
    w_step = r_work;
    case (i_op)
      SLL_OP:  w_step = {r_work[DATA_WIDTH-2:0], 1'b0};
      SRL_OP:  w_step = {1'b0, r_work[DATA_WIDTH-1:1]};
      SRA_OP:  w_step = {r_work[DATA_WIDTH-1], r_work[DATA_WIDTH-1:1]};
      default: w_step = r_work;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_next = SHIFT;
      SHIFT:   if (w_last)  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_result = i_data;
    o_done   = 1'b0;
    if (i_shamt == '0) begin
      o_result = i_data;
      o_done   = 1'b1;
    end else if (r_state == SHIFT) begin
      o_result = w_step;
      o_done   = w_last;
    end else if (r_done) begin
      o_result = r_work;
      o_done   = 1'b1;
    end
  end

  // Working register and bit counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_work  <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      if (w_start) begin
        r_work  <= i_data;
        r_count <= i_shamt;
      end else if (r_state == SHIFT) begin
        r_work  <= w_step;
        r_count <= r_count - 1'b1;
      end
      if (i_advance)
        r_done <= 1'b0;
      else if (w_last)
        r_done <= 1'b1;
    end
  end

`else

  always_comb begin
    o_result = '0;
    case (i_op)
      SLL_OP:  o_result = i_data << i_shamt;
      SRL_OP:  o_result = i_data >> i_shamt;
      SRA_OP:  o_result = $signed(i_data) >>> i_shamt;
      default: o_result = '0;
    endcase
  end

  assign o_done = 1'b1;

`endif

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU with a 2-stage valid/ready pipeline
// (S1 input register, S2 output register). Full throughput of one beat per
// cycle, fill latency 2 cycles. Tag is carried through untouched.
// Macro SERIAL_SHIFT_EN selects the serial shift engine in alu_shifter
// (shift latency 2 + shamt); undefined gives a barrel shifter.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   i_valid / o_ready   input handshake
//   i_ALUOp             op code (riscv_pkg encodings)
//   i_op1, i_op2        operands; shift amount is i_op2[$clog2(DATA_WIDTH)-1:0]
//   i_tag               sideband tag
//   o_valid / i_ready   output handshake
//   o_result, o_tag     result beat
//   o_zero              o_result == 0
module alu_exec_unit
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [ALUOP_WIDTH-1:0] i_ALUOp,
  input  logic [DATA_WIDTH-1:0]  i_op1,
  input  logic [DATA_WIDTH-1:0]  i_op2,
  input  logic [TAG_WIDTH-1:0]   i_tag,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [DATA_WIDTH-1:0]  o_result,
  output logic [TAG_WIDTH-1:0]   o_tag,
  output logic                   o_zero
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  // S1
  logic                   r_s1_valid;
  logic [ALUOP_WIDTH-1:0] r_s1_op;
  logic [DATA_WIDTH-1:0]  r_s1_op1;
  logic [DATA_WIDTH-1:0]  r_s1_op2;
  logic [TAG_WIDTH-1:0]   r_s1_tag;
  // S2
  logic                   r_s2_valid;
  logic [DATA_WIDTH-1:0]  r_result;
  logic [TAG_WIDTH-1:0]   r_tag;
  logic                   r_zero;

  logic                   w_in_fire;
  logic                   w_out_fire;
  logic                   w_s1_is_shift;
  logic                   w_s1_done;
  logic                   w_s1_advance;
  logic [DATA_WIDTH-1:0]  w_shift_result;
  logic                   w_shift_done;
  logic [DATA_WIDTH-1:0]  w_alu_result;

  assign w_s1_is_shift = is_shift_op(r_s1_op);
  assign w_s1_done     = !w_s1_is_shift || w_shift_done;
  assign w_out_fire    = r_s2_valid && i_ready;
  assign w_s1_advance  = r_s1_valid && w_s1_done && (!r_s2_valid || i_ready);
  assign o_ready       = !r_s1_valid || w_s1_advance;
  assign w_in_fire     = i_valid && o_ready;

  alu_shifter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shifter (
`ifdef SERIAL_SHIFT_EN
    .clk       (clk),
    .reset     (reset),
    .i_valid   (r_s1_valid && w_s1_is_shift),
    .i_advance (w_s1_advance),
`endif
    .i_op      (r_s1_op),
    .i_data    (r_s1_op1),
    .i_shamt   (r_s1_op2[SHAMT_W-1:0]),
    .o_result  (w_shift_result),
    .o_done    (w_shift_done)
  );

  always_comb begin
    w_alu_result = '0;
    case (r_s1_op)
      ADD_OP:  w_alu_result = r_s1_op1 + r_s1_op2;
      SUB_OP:  w_alu_result = r_s1_op1 - r_s1_op2;
      SLL_OP,
      SRL_OP,
      SRA_OP:  w_alu_result = w_shift_result;
      SLT_OP:  w_alu_result[0] = $signed(r_s1_op1) < $signed(r_s1_op2);
      SLTU_OP: w_alu_result[0] = r_s1_op1 < r_s1_op2;
      XOR_OP:  w_alu_result = r_s1_op1 ^ r_s1_op2;
      OR_OP:   w_alu_result = r_s1_op1 | r_s1_op2;
      AND_OP:  w_alu_result = r_s1_op1 & r_s1_op2;
      PASS_OP: w_alu_result = r_s1_op2;
      default: w_alu_result = '0;
    endcase
  end

  // S1: a load wins over a drain, so accept + advance in one cycle keeps it full.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_op1   <= '0;
      r_s1_op2   <= '0;
      r_s1_tag   <= '0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_op    <= i_ALUOp;
      r_s1_op1   <= i_op1;
      r_s1_op2   <= i_op2;
      r_s1_tag   <= i_tag;
    end else if (w_s1_advance) begin
      r_s1_valid <= 1'b0;
    end
  end

  // S2: result/tag only change on an S1 move, which requires S2 empty or
  // firing, so a stalled beat is held stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_tag      <= '0;
      r_zero     <= 1'b1;
    end else if (w_s1_advance) begin
      r_s2_valid <= 1'b1;
      r_result   <= w_alu_result;
      r_tag      <= r_s1_tag;
      r_zero     <= (w_alu_result == '0);
    end else if (w_out_fire) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign o_valid  = r_s2_valid;
  assign o_result = r_result;
  assign o_tag    = r_tag;
  assign o_zero   = r_zero;

endmodule
